// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch/decode front end; reads the instruction at pc, resolves the indirect operand, hands ir+eff_addr to the control unit.
// Latency: with zero-wait memory ir_valid comes 2 cycles after entering FETCH (direct) or 3 (indirect); each memory wait cycle adds one.
// Backpressure: ir/eff_addr/ind_bit held until ir_ready; no new fetch before the handshake. Optional macro FETCH_TIMEOUT_EN adds a memory timeout fault.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] eff_addr,
  output logic              ind_bit,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              pc_skip,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              o_fault
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    IND    = 3'd3,
    ISSUE  = 3'd4,
    HALTED = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  logic handshake;
  logic mem_ref;
  logic is_indirect;
  logic timeout;

  // Opcode 7 is register-reference / I/O: its bit 15 never selects indirection.
  assign mem_ref     = (ir[14:12] != 3'd7);
  assign is_indirect = mem_ref && ir[15];
  assign handshake   = (state == ISSUE) && ir_ready;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // The same cycle that would fault still accepts a late ack.
  assign timeout = mem_req && !mem_ack && (wait_cnt == 8'hFF);

  // Wait counter restarts whenever no request is outstanding or one completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 8'h00;
    end else if (!mem_req || mem_ack) begin
      wait_cnt <= 8'h00;
    end else begin
      wait_cnt <= wait_cnt + 8'h01;
    end
  end

  // Sticky fault flag: only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_fault <= 1'b0;
    end else if (timeout) begin
      o_fault <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign o_fault = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore outputs; memory request/address are purely state-decoded.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_addr  = '0;
    ir_valid  = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) begin
          state_nxt = DECODE;
        end else if (timeout) begin
          state_nxt = HALTED;
        end
      end
      DECODE: begin
        state_nxt = is_indirect ? IND : ISSUE;
      end
      IND: begin
        mem_req  = 1'b1;
        mem_addr = ir[ADDR_W-1:0];
        if (mem_ack) begin
          state_nxt = ISSUE;
        end else if (timeout) begin
          state_nxt = HALTED;
        end
      end
      ISSUE: begin
        ir_valid = 1'b1;
        if (ir_ready) begin
          state_nxt = halt ? HALTED : FETCH;
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Program counter: post-increment on fetch, then branch/skip applied at the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (state == FETCH && mem_ack) begin
      pc <= pc + 1'b1;
    end else if (handshake) begin
      if (pc_load) begin
        pc <= pc_load_val;
      end else if (pc_skip) begin
        pc <= pc + 1'b1;
      end
    end
  end

  // Instruction register: captured once per fetch, held through ISSUE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir <= '0;
    end else if (state == FETCH && mem_ack) begin
      ir <= mem_rdata;
    end
  end

  // Effective address and indirect flag: direct path resolves in DECODE, indirect in IND.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eff_addr <= '0;
      ind_bit  <= 1'b0;
    end else if (state == DECODE) begin
      ind_bit <= is_indirect;
      if (!is_indirect) begin
        eff_addr <= ir[ADDR_W-1:0];
      end
    end else if (state == IND && mem_ack) begin
      eff_addr <= mem_rdata[ADDR_W-1:0];
    end
  end

endmodule
